// File: rtl/axi_pkt_admit.sv
// Whole-packet admission controller for the channelizer FIFOs, with a 2-entry output buffer.
// Define AXI_PKT_ADMIT_STATS_EN to build the drop/pass counters and the sticky overrun flag.
module axi_pkt_admit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  almost_full,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  stat_clr,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  pass_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              occ_reg, occ_next;
  logic [DATA_WIDTH-1:0]   head_data_reg, head_data_next, skid_data_reg, skid_data_next;
  logic                    head_last_reg, head_last_next, skid_last_reg, skid_last_next;
  logic                    pop, space, push, force_last;
  logic                    drop_inc, pass_inc, overrun_set;

  assign pop   = (occ_reg != 2'd0) && m_axis_tready;
  assign space = (occ_reg != 2'd2) || pop;

  always_comb begin
    state_next  = state_reg;
    push        = 1'b0;
    force_last  = 1'b0;
    drop_inc    = 1'b0;
    pass_inc    = 1'b0;
    overrun_set = 1'b0;
    case (state_reg)
      IDLE: if (s_axis_tvalid) begin
        if (!almost_full && space) begin
          push = 1'b1;
          if (s_axis_tlast) pass_inc = 1'b1;
          else              state_next = PASS;
        end else begin
          drop_inc = 1'b1;
          if (!s_axis_tlast) state_next = DROP;
        end
      end
      PASS: if (s_axis_tvalid) begin
        if (space) begin
          push = 1'b1;
          if (s_axis_tlast) begin
            pass_inc   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          // No space means both entries held and no pop: close the packet on the skid entry.
          force_last  = 1'b1;
          overrun_set = 1'b1;
          drop_inc    = 1'b1;
          state_next  = s_axis_tlast ? IDLE : DROP;
        end
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    occ_next       = occ_reg;
    head_data_next = head_data_reg;
    head_last_next = head_last_reg;
    skid_data_next = skid_data_reg;
    skid_last_next = skid_last_reg | force_last;
    case (occ_reg)
      2'd0: if (push) begin
        head_data_next = s_axis_tdata;
        head_last_next = s_axis_tlast;
        occ_next       = 2'd1;
      end
      2'd1: case ({push, pop})
        2'b11: begin
          head_data_next = s_axis_tdata;
          head_last_next = s_axis_tlast;
        end
        2'b10: begin
          skid_data_next = s_axis_tdata;
          skid_last_next = s_axis_tlast;
          occ_next       = 2'd2;
        end
        2'b01:   occ_next = 2'd0;
        default: occ_next = 2'd1;
      endcase
      2'd2: if (pop) begin
        head_data_next = skid_data_reg;
        head_last_next = skid_last_reg;
        if (push) begin
          skid_data_next = s_axis_tdata;
          skid_last_next = s_axis_tlast;
        end else begin
          occ_next = 2'd1;
        end
      end
      default: occ_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_reg     <= IDLE;
      occ_reg       <= 2'd0;
      head_data_reg <= '0;
      head_last_reg <= 1'b0;
      skid_data_reg <= '0;
      skid_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      occ_reg       <= occ_next;
      head_data_reg <= head_data_next;
      head_last_reg <= head_last_next;
      skid_data_reg <= skid_data_next;
      skid_last_reg <= skid_last_next;
    end
  end

  assign m_axis_tvalid = (occ_reg != 2'd0);
  assign m_axis_tdata  = head_data_reg;
  assign m_axis_tlast  = head_last_reg;

`ifdef AXI_PKT_ADMIT_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  logic       overrun_reg;
  logic [1:0] cnt_inc;

  assign cnt_inc = {pass_inc, drop_inc};

  always_ff @(posedge clk) begin
    if (sync_reset || stat_clr) overrun_reg <= 1'b0;
    else if (overrun_set)       overrun_reg <= 1'b1;
  end

  // Index 0 counts drops/truncations, index 1 intact packets; both saturate.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (sync_reset || stat_clr)          cnt_reg <= '0;
      else if (cnt_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  assign overrun  = overrun_reg;
  assign drop_cnt = g_cnt[0].cnt_reg;
  assign pass_cnt = g_cnt[1].cnt_reg;
`else
  logic unused_stats;
  assign unused_stats = ^{stat_clr, drop_inc, pass_inc, overrun_set};
  assign overrun  = 1'b0;
  assign drop_cnt = '0;
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_pkt_admit.sv
// Bench for axi_pkt_admit: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based packet admission model.
module tb_axi_pkt_admit;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef AXI_PKT_ADMIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          sync_reset, s_axis_tvalid, s_axis_tlast, almost_full;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready, stat_clr, overrun;
  logic [DW-1:0] m_axis_tdata;
  logic [CW-1:0] drop_cnt, pass_cnt;

  int n_total = 0;
  int n_pass  = 0;

  axi_pkt_admit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .almost_full(almost_full),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .stat_clr(stat_clr), .overrun(overrun),
    .drop_cnt(drop_cnt), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] stat_exp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l, input logic af,
                     input logic r, input logic rst, input logic clr);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; almost_full = af;
    m_axis_tready = r; sync_reset = rst; stat_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [DW-1:0] ed, input logic el);
    chk({name, ".valid"}, 32'(m_axis_tvalid), 32'(ev));
    if (ev) begin
      chk({name, ".data"}, m_axis_tdata, ed);
      chk({name, ".last"}, 32'(m_axis_tlast), 32'(el));
    end
  endtask

  task automatic chk_stats(input string name, input int eo, input int ed, input int ep);
    chk({name, ".overrun"},  32'(overrun),  stat_exp(eo));
    chk({name, ".drop_cnt"}, 32'(drop_cnt), stat_exp(ed));
    chk({name, ".pass_cnt"}, 32'(pass_cnt), stat_exp(ep));
  endtask

  typedef struct {
    logic v; logic [DW-1:0] d; logic l; logic af; logic r;
    logic ev; logic [DW-1:0] ed; logic el;
  } vec_t;
  vec_t vt[$];

  // Reference model: buffered beats in order, packet state, statistics.
  localparam int M_IDLE = 0, M_PASS = 1, M_DROP = 2;
  logic [DW:0] mq[$];
  int mst, m_over, m_drop, m_pass;

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic l, input logic af,
                            input logic r, input logic rst, input logic clr);
    bit pop, space, push, force_l, dinc, pinc, oset;
    logic [DW:0] tmp;
    if (rst) begin
      mq.delete(); mst = M_IDLE; m_over = 0; m_drop = 0; m_pass = 0;
      return;
    end
    pop = (mq.size() > 0) && r;
    space = (mq.size() < 2) || pop;
    push = 0; force_l = 0; dinc = 0; pinc = 0; oset = 0;
    if (v) begin
      if (mst == M_IDLE) begin
        if (!af && space) begin push = 1; if (l) pinc = 1; else mst = M_PASS; end
        else begin dinc = 1; if (!l) mst = M_DROP; end
      end else if (mst == M_PASS) begin
        if (space) begin push = 1; if (l) begin pinc = 1; mst = M_IDLE; end end
        else begin force_l = 1; oset = 1; dinc = 1; mst = l ? M_IDLE : M_DROP; end
      end else if (l) begin
        mst = M_IDLE;
      end
    end
    if (pop) void'(mq.pop_front());
    if (force_l) begin tmp = mq.pop_back(); tmp[DW] = 1'b1; mq.push_back(tmp); end
    if (push) mq.push_back({l, d});
    if (clr) begin
      m_over = 0; m_drop = 0; m_pass = 0;
    end else begin
      if (oset) m_over = 1;
      if (dinc && m_drop < CNT_MAX) m_drop++;
      if (pinc && m_pass < CNT_MAX) m_pass++;
    end
  endtask

  initial begin
    logic v, l, af, r, rst, clr;
    logic [DW-1:0] d;
    logic [DW:0] hd;

    // reset state
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("reset.valid", 32'(m_axis_tvalid), 0);
    chk("reset.data",  m_axis_tdata, 0);
    chk("reset.last",  32'(m_axis_tlast), 0);
    chk_stats("reset", 0, 0, 0);

    // 4-beat pass, dropped 3-beat (af on beat 1 only), 2-beat pass, 5-beat with af rising mid-packet
    vt.push_back('{1, 1, 0, 0, 1,  1, 1, 0});
    vt.push_back('{1, 2, 0, 0, 1,  1, 2, 0});
    vt.push_back('{1, 3, 0, 0, 1,  1, 3, 0});
    vt.push_back('{1, 4, 1, 0, 1,  1, 4, 1});
    vt.push_back('{0, 0, 0, 0, 1,  0, 0, 0});
    vt.push_back('{1, 7, 0, 1, 1,  0, 0, 0});
    vt.push_back('{1, 8, 0, 0, 1,  0, 0, 0});
    vt.push_back('{1, 9, 1, 0, 1,  0, 0, 0});
    vt.push_back('{1, 20, 0, 0, 1, 1, 20, 0});
    vt.push_back('{1, 21, 1, 0, 1, 1, 21, 1});
    vt.push_back('{0, 0, 0, 0, 1,  0, 0, 0});
    vt.push_back('{1, 30, 0, 0, 1, 1, 30, 0});
    vt.push_back('{1, 31, 0, 1, 1, 1, 31, 0});
    vt.push_back('{0, 0, 0, 1, 1,  0, 0, 0});
    vt.push_back('{1, 32, 0, 1, 1, 1, 32, 0});
    vt.push_back('{1, 33, 0, 1, 1, 1, 33, 0});
    vt.push_back('{1, 34, 1, 1, 1, 1, 34, 1});
    vt.push_back('{0, 0, 0, 0, 1,  0, 0, 0});
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].v, vt[i].d, vt[i].l, vt[i].af, vt[i].r, 0, 0);
      chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].el);
    end
    chk_stats("table", 0, 1, 3);

    // overrun truncation with ready low from the start
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 10; k <= 15; k++) begin
      cyc(1, k, k == 15, 0, 0, 0, 0);
      chk_out($sformatf("ovr_beat%0d", k), 1, 10, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk_out("ovr_pop1", 1, 11, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk_out("ovr_empty", 0, 0, 0);
    chk_stats("ovr", 1, 1, 0);

    // full buffer with a pop in the same cycle as a new beat
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk_stats("clr", 0, 0, 0);
    cyc(1, 40, 0, 0, 0, 0, 0);
    cyc(1, 41, 0, 0, 0, 0, 0);
    chk_out("full_hold", 1, 40, 0);
    cyc(1, 42, 0, 0, 1, 0, 0);
    chk_out("full_pp1", 1, 41, 0);
    cyc(1, 43, 1, 0, 1, 0, 0);
    chk_out("full_pp2", 1, 42, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk_out("full_drain", 1, 43, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk_out("full_empty", 0, 0, 0);
    chk_stats("full", 0, 0, 1);

    // reset mid-packet, then clear coinciding with a dropped first beat
    cyc(1, 50, 0, 0, 0, 0, 0);
    cyc(1, 51, 0, 0, 0, 0, 0);
    chk_out("rst_pre", 1, 50, 0);
    cyc(1, 52, 0, 0, 0, 1, 0);
    chk_out("rst_mid", 0, 0, 0);
    chk_stats("rst_mid", 0, 0, 0);
    cyc(1, 53, 0, 1, 1, 0, 1);
    chk_out("clr_drop", 0, 0, 0);
    chk_stats("clr_drop", 0, 0, 0);
    cyc(1, 54, 1, 0, 1, 0, 0);
    chk_out("drop_tail", 0, 0, 0);
    cyc(1, 60, 1, 0, 1, 0, 0);
    chk_out("after_rst", 1, 60, 1);
    chk_stats("after_rst", 0, 0, 1);

    // saturation, then clear winning over an increment
    for (int k = 0; k < 20; k++) cyc(1, k, 1, 0, 1, 0, 0);
    chk_stats("sat", 0, 0, CNT_MAX);
    cyc(1, 99, 1, 0, 1, 0, 1);
    chk_stats("clr_inc", 0, 0, 0);

    // randomized traffic against the model
    cyc(0, 0, 0, 0, 1, 1, 0);
    model_step(0, 0, 0, 0, 1, 1, 0);
    for (int n = 0; n < 4000; n++) begin
      chk(n == 0 ? "rnd.valid" : "rnd.valid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        hd = mq[0];
        chk("rnd.data", m_axis_tdata, hd[DW-1:0]);
        chk("rnd.last", 32'(m_axis_tlast), 32'(hd[DW]));
      end
      chk_stats("rnd", m_over, m_drop, m_pass);
      v   = ($urandom_range(0, 9) < 7);
      d   = $urandom;
      l   = ($urandom_range(0, 9) < 3);
      af  = ($urandom_range(0, 9) < 2);
      r   = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 499) == 0);
      clr = ($urandom_range(0, 99) < 2);
      model_step(v, d, l, af, r, rst, clr);
      cyc(v, d, l, af, r, rst, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
